cam_capture_ctrl: RTL and testbench
===================================

# cam_capture_ctrl

Capture sequencer for the camera-to-framebuffer path. It accepts start/stop/single-shot commands and holds the YCbCr-to-RGB capture datapath in reset until a clean frame boundary. It then enables the datapath for whole frames only. While a frame runs, it checks line and frame geometry against the sensor's `href`/`cam_vsync` timing, and it reports frame completion, a frame counter and sticky error flags to the control logic.

## Interface
- `H_BYTES`, 1280: expected `href`-high byte cycles per line (640 px × 2 bytes).
- `V_LINES`, 480: expected lines per frame.
- `FCNT_W`, 8: frame counter width.
- `TIMEOUT_CYCLES`, 1000000: watchdog limit in `pclk` cycles; used only with `CAM_CTRL_TIMEOUT_EN`.

- `pclk` in 1: camera pixel clock; all logic is on this clock.
- `reset` in 1: synchronous, active-high.
- `cmd_start` in 1: one-cycle request to begin capture.
- `cmd_single` in 1: sampled with `cmd_start`; 1 = capture one frame only.
- `cmd_stop` in 1: one-cycle request to stop capture.
- `cam_vsync` in 1: sensor vsync; high = blanking.
- `href` in 1: sensor line-valid.
- `dp_reset` out 1: reset to the capture datapath.
- `capture_en` out 1: frame window; gates framebuffer writes.
- `busy` out 1: high whenever state ≠ IDLE.
- `frame_done` out 1: one-cycle pulse at each completed frame.
- `frame_count` out `FCNT_W`: number of completed frames; wraps.
- `err` out 3: sticky error flags `{timeout, frame_len, line_len}`.

## Operation
- States:
  - IDLE: `dp_reset`=1, `capture_en`=0.
  - ARM: wait for `cam_vsync`=1; `dp_reset`=1.
  - SYNC: wait for `cam_vsync`=0; `dp_reset`=0.
  - ACTIVE: `capture_en`=1.
- IDLE→ARM on `cmd_start`. The same cycle latches `single` ← `cmd_single`, clears `err`, clears `stop_pend`, and zeroes the line and byte counters. `frame_count` is not cleared.
- ARM→SYNC when `cam_vsync`=1.
- SYNC→ACTIVE when `cam_vsync`=0. Line and byte counters are zeroed on this transition.
- In ACTIVE:
  - The byte counter increments on every cycle with `href`=1 and saturates at all-ones.
  - On an `href` falling edge (`href_q`=1, `href`=0), compare the byte count with `H_BYTES`. A mismatch sets `err[0]`. The line counter then increments (saturating) and the byte counter is cleared.
- ACTIVE exits when `cam_vsync` rises (`vsync_q`=0, `vsync`=1):
  - If the line count ≠ `V_LINES`, set `err[1]`.
  - `frame_count`++ and pulse `frame_done`.
  - If `single` or `stop_pend` → IDLE; otherwise → SYNC (continuous capture with no re-arm).
- `cmd_stop`:
  - In ARM/SYNC: go to IDLE immediately.
  - In ACTIVE: set `stop_pend`; the current frame completes normally.
  - In IDLE: ignored.
- `cmd_start` while `busy` is ignored.
- `cmd_start` and `cmd_stop` in the same cycle in IDLE: stop wins, block stays in IDLE.
- An `href` falling edge and a `cam_vsync` rise in the same cycle: the line check is applied first, then the frame check uses the updated line count.

## Timing
- All outputs are registered. Reset values: `dp_reset`=1, `capture_en`=0, `busy`=0, `frame_done`=0, `frame_count`=0, `err`=0, `stop_pend`=0, state IDLE.
- A state change occurs at the edge where its condition is sampled; outputs reflect the new state in the following cycle (1-cycle latency).
- `frame_done` is high for exactly one cycle, coincident with `capture_en` falling.
- Line-check result and `err[0]` are visible 1 cycle after the `href` falling edge.
- `reset` asserted mid-frame: next cycle all outputs return to reset values and any pending stop is discarded.
- `cam_vsync` and `href` are sampled directly; they are in the `pclk` domain.

## Configuration
- `CAM_CTRL_TIMEOUT_EN` defined: a watchdog counter runs in ARM, SYNC and ACTIVE.
  - It clears on every `cam_vsync` edge and on every state change.
  - On reaching `TIMEOUT_CYCLES` it sets `err[2]` and forces IDLE. `frame_done` is not pulsed and `frame_count` is unchanged.
- Not defined: no watchdog counter is built and `err[2]` is tied to 0.

## Structure
- Package `cam_pkg`: state encoding (IDLE=0, ARM=1, SYNC=2, ACTIVE=3) and error-bit indices (`ERR_LINE`=0, `ERR_FRAME`=1, `ERR_TIMEOUT`=2).
- Sub-module `cam_line_checker`: contains `href` edge detection, the saturating byte counter, the `H_BYTES` compare and the line counter. Outputs `line_end`, `line_bad` and `line_count`.
- Top level holds the FSM, `frame_count`, the error register and the watchdog.

## Test plan
All scenarios use `H_BYTES`=8, `V_LINES`=4, `TIMEOUT_CYCLES`=200.

- Single shot: `cmd_start` with `cmd_single`=1, then 2 frames of 4 lines × 8 bytes.
  - Exactly one `frame_done`; `frame_count`=1; `err`=0.
  - `capture_en` spans only frame 1; back in IDLE with `dp_reset`=1.
- Continuous with stop: `cmd_start` with `cmd_single`=0, 3 frames, `cmd_stop` mid frame 3.
  - Frame 3 completes; `frame_count`=3; then IDLE.
- Bad line: one line of 7 bytes → `err`=3'b001 after that line, frame still completes.
- Bad frame: a frame of 3 lines → `err`=3'b010 with `frame_done` still pulsed.
- Arm mid-frame: start with `cam_vsync` low during lines.
  - `capture_en` stays 0 until the full vsync high→low sequence has been seen.
- Timeout (macro on): `cam_vsync` held at 0 after `cmd_start` → `err`=3'b100, IDLE after 200 cycles.
- Reset at line 2 of a frame → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the camera capture sequencer:
//   - cam_state_t : FSM state encoding (IDLE=0, ARM=1, SYNC=2, ACTIVE=3)
//   - ERR_*       : bit positions inside the sticky err[2:0] vector
//   - cnt_width() : width of a saturating counter that must hold max_val and
//                   still have headroom above it, so an overlong line/frame
//                   can never alias back onto the expected value.
// -----------------------------------------------------------------------------
package cam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_SYNC   = 2'd2,
        ST_ACTIVE = 2'd3
    } cam_state_t;

    localparam int ERR_LINE    = 0;
    localparam int ERR_FRAME   = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_W       = 3;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1) + 1;
    endfunction

endpackage

// File: rtl/cam_line_checker.sv
// -----------------------------------------------------------------------------
// cam_line_checker
// Line geometry checker for one capture frame.
//   pclk, reset : clock, synchronous active-high reset
//   clear       : zero the byte and line counters (start of arm / frame)
//   enable      : high while the sequencer is in ACTIVE
//   href        : sensor line-valid, pclk domain
//   line_end    : combinational, high on the href falling edge while enabled
//   line_bad    : combinational, line_end with byte count != H_BYTES
//   line_count  : registered count of completed lines (saturating)
// The byte counter saturates at all-ones so very long lines still compare as
// a mismatch instead of wrapping.
// -----------------------------------------------------------------------------
module cam_line_checker
    import cam_pkg::*;
#(
    parameter int H_BYTES = 1280,
    parameter int LC_W    = 10
) (
    input  logic            pclk,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    input  logic            href,
    output logic            line_end,
    output logic            line_bad,
    output logic [LC_W-1:0] line_count
);

    localparam int              BC_W      = cnt_width(H_BYTES);
    localparam logic [BC_W-1:0] H_BYTES_V = BC_W'(H_BYTES);

    logic            href_q;
    logic [BC_W-1:0] byte_count;

    assign line_end = enable && href_q && !href;
    assign line_bad = line_end && (byte_count != H_BYTES_V);

    always_ff @(posedge pclk) begin
        if (reset) begin
            href_q     <= 1'b0;
            byte_count <= '0;
            line_count <= '0;
        end else begin
            // href_q tracks always so the first edge after entering ACTIVE
            // is judged against the real previous level.
            href_q <= href;
            if (clear) begin
                byte_count <= '0;
                line_count <= '0;
            end else if (line_end) begin
                byte_count <= '0;
                if (line_count != '1) begin
                    line_count <= line_count + 1'b1;
                end
            end else if (enable && href && (byte_count != '1)) begin
                byte_count <= byte_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// cam_capture_ctrl
// Capture sequencer for the camera-to-framebuffer path. Holds the capture
// datapath in reset until a clean frame boundary, enables it for whole frames
// only, checks line/frame geometry and reports completion and errors.
//
// Ports:
//   pclk, reset            : pixel clock, synchronous active-high reset
//   cmd_start, cmd_single  : start request; cmd_single=1 captures one frame
//   cmd_stop               : stop request (deferred to frame end in ACTIVE)
//   cam_vsync, href        : sensor timing (vsync high = blanking)
//   dp_reset               : datapath reset (high in IDLE and ARM)
//   capture_en             : frame window, high in ACTIVE
//   busy                   : state != IDLE
//   frame_done             : one-cycle pulse per completed frame
//   frame_count            : completed frames, wraps
//   err                    : sticky {timeout, frame_len, line_len}
//   fsm_state              : current FSM state, for debug/observation
//
// Build option: define CAM_CTRL_TIMEOUT_EN to build the watchdog; without it
// err[2] stays 0 and no watchdog counter exists.
//
// Handshake: cmd_start/cmd_stop are single-cycle strobes sampled on every pclk
// edge; there is no ready/acknowledge, a strobe that is not applicable in the
// current state is simply dropped. All outputs are registered and reflect the
// state entered at the edge where the condition was sampled.
// -----------------------------------------------------------------------------
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_BYTES        = 1280,
    parameter int V_LINES        = 480,
    parameter int FCNT_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              cmd_single,
    input  logic              cmd_stop,
    input  logic              cam_vsync,
    input  logic              href,
    output logic              dp_reset,
    output logic              capture_en,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_count,
    output logic [ERR_W-1:0]  err,
    output cam_state_t        fsm_state
);

    localparam int              LC_W      = cnt_width(V_LINES);
    localparam logic [LC_W-1:0] V_LINES_V = LC_W'(V_LINES);

    cam_state_t      state;
    cam_state_t      state_next;
    logic            single;
    logic            stop_pend;
    logic            vsync_q;
    logic            vsync_rise;
    logic            start_ok;
    logic            frame_end;
    logic            timeout;
    logic            counter_clear;
    logic            line_end;
    logic            line_bad;
    logic [LC_W-1:0] line_count;
    logic [LC_W-1:0] frame_lines;

    assign vsync_rise = !vsync_q && cam_vsync;
    // A stop in the same cycle as a start in IDLE wins.
    assign start_ok   = (state == ST_IDLE) && cmd_start && !cmd_stop;
    assign frame_end  = (state == ST_ACTIVE) && vsync_rise && !timeout;
    assign counter_clear = start_ok ||
                           ((state == ST_SYNC) && (state_next == ST_ACTIVE));

    // Line count as it will be after this cycle's line check, so a line that
    // ends on the same edge as the vsync rise is counted in the frame check.
    assign frame_lines = (line_end && (line_count != '1)) ? line_count + 1'b1
                                                          : line_count;

    assign fsm_state = state;

    cam_line_checker #(
        .H_BYTES (H_BYTES),
        .LC_W    (LC_W)
    ) u_line_checker (
        .pclk       (pclk),
        .reset      (reset),
        .clear      (counter_clear),
        .enable     (state == ST_ACTIVE),
        .href       (href),
        .line_end   (line_end),
        .line_bad   (line_bad),
        .line_count (line_count)
    );

`ifdef CAM_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_count;

    assign timeout = (state != ST_IDLE) &&
                     (wd_count == WD_W'(TIMEOUT_CYCLES - 1));

    // Any sign of life (vsync edge) or progress (state change) restarts it.
    always_ff @(posedge pclk) begin
        if (reset || (state == ST_IDLE) || (state_next != state) ||
            (cam_vsync != vsync_q)) begin
            wd_count <= '0;
        end else begin
            wd_count <= wd_count + 1'b1;
        end
    end
`else
    // No watchdog in this build; the parameter stays in the list so both
    // builds share one interface, and this expression is constant false.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_next = ST_ARM;
            end
            ST_ARM: begin
                if (cmd_stop)       state_next = ST_IDLE;
                else if (cam_vsync) state_next = ST_SYNC;
            end
            ST_SYNC: begin
                if (cmd_stop)        state_next = ST_IDLE;
                else if (!cam_vsync) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // A stop arriving on the closing edge itself also ends capture.
                if (vsync_rise) begin
                    state_next = (single || stop_pend || cmd_stop) ? ST_IDLE
                                                                   : ST_SYNC;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (timeout) state_next = ST_IDLE;
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state       <= ST_IDLE;
            dp_reset    <= 1'b1;
            capture_en  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            err         <= '0;
            single      <= 1'b0;
            stop_pend   <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            vsync_q    <= cam_vsync;
            state      <= state_next;
            dp_reset   <= (state_next == ST_IDLE) || (state_next == ST_ARM);
            capture_en <= (state_next == ST_ACTIVE);
            busy       <= (state_next != ST_IDLE);
            frame_done <= frame_end;

            if (frame_end) begin
                frame_count <= frame_count + 1'b1;
            end

            if (start_ok) begin
                single    <= cmd_single;
                stop_pend <= 1'b0;
                err       <= '0;
            end else begin
                if ((state == ST_ACTIVE) && cmd_stop) stop_pend <= 1'b1;
                if (state_next == ST_IDLE)            stop_pend <= 1'b0;
                if (line_bad)                         err[ERR_LINE] <= 1'b1;
                if (frame_end && (frame_lines != V_LINES_V)) begin
                    err[ERR_FRAME] <= 1'b1;
                end
                if (timeout)                          err[ERR_TIMEOUT] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cam_capture_ctrl
// Directed-plus-random bench for cam_capture_ctrl with small geometry
// (8 bytes/line, 4 lines/frame, 200-cycle watchdog). The reference model
// tracks capture at frame granularity: which frames are captured, how many
// frames complete, which sticky errors accrue and whether the block is busy.
// -----------------------------------------------------------------------------
module tb_cam_capture_ctrl;
    import cam_pkg::*;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int FW = 8;
    localparam int TO = 200;

    // clock / reset / stimulus
    logic pclk = 1'b0;
    logic reset, cmd_start, cmd_single, cmd_stop, cam_vsync, href;
    logic dp_reset, capture_en, busy, frame_done;
    logic [FW-1:0] frame_count;
    logic [2:0]    err;
    cam_state_t    fsm_state;

    always #5 pclk = ~pclk;

    cam_capture_ctrl #(
        .H_BYTES        (H),
        .V_LINES        (V),
        .FCNT_W         (FW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .cmd_start   (cmd_start),
        .cmd_single  (cmd_single),
        .cmd_stop    (cmd_stop),
        .cam_vsync   (cam_vsync),
        .href        (href),
        .dp_reset    (dp_reset),
        .capture_en  (capture_en),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err         (err),
        .fsm_state   (fsm_state)
    );

    // scoreboard counters
    int checks = 0;
    int errors = 0;

    // reference model: mode 0 = idle, 1 = single shot, 2 = continuous
    int       m_mode  = 0;
    bit       m_ready = 0;   // a vsync high has been seen since arming
    bit       m_stop  = 0;   // stop requested during a captured frame
    int       m_fc    = 0;
    logic [2:0] m_err = '0;

    int cap_cnt;
    int done_cnt;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample outputs 1 time unit after the active edge.
    task automatic step();
        @(posedge pclk);
        #1;
        if (capture_en === 1'b1) cap_cnt++;
        if (frame_done === 1'b1) done_cnt++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dp_reset"},   dp_reset,    1);
        check({tag, "_capture_en"}, capture_en,  0);
        check({tag, "_busy"},       busy,        0);
        check({tag, "_frame_done"}, frame_done,  0);
        check({tag, "_frame_count"},frame_count, 0);
        check({tag, "_err"},        err,         0);
        check({tag, "_state"},      fsm_state,   ST_IDLE);
    endtask

    // One command strobe during vertical blanking, then two settle cycles.
    task automatic blank_cmd(input string tag, input bit st, input bit sg,
                             input bit sp);
        cam_vsync = 1'b1; href = 1'b0;
        cmd_start = st; cmd_single = sg; cmd_stop = sp;
        step();
        cmd_start = 1'b0; cmd_single = 1'b0; cmd_stop = 1'b0;
        if (sp) begin
            m_mode = 0;
        end else if (st && (m_mode == 0)) begin
            m_mode = sg ? 1 : 2;
            m_err  = '0;
            m_stop = 0;
        end
        m_ready = (m_mode != 0);
        repeat (2) step();
        check({tag, "_busy"},     busy,     (m_mode != 0));
        check({tag, "_dp_reset"}, dp_reset, (m_mode == 0));
    endtask

    // One sensor frame: vsync low, nlines lines (line bad_idx has bad_len
    // bytes), then vsync high blanking. cmd_kind at the first byte of
    // cmd_line: 0 start single, 1 start continuous, 2 stop, 3 reset.
    task automatic run_frame(input string name, input int nlines,
                             input int bad_idx, input int bad_len,
                             input int cmd_line, input int cmd_kind);
        bit captured;
        bit was_reset;
        int low, porch, len, gap, blank, exp_cap, exp_done;
        captured  = (m_mode != 0) && m_ready;
        was_reset = 0;
        low = 0; cap_cnt = 0; done_cnt = 0;
        porch = $urandom_range(1, 3);
        cam_vsync = 1'b0; href = 1'b0;
        repeat (porch) begin step(); low++; end
        for (int l = 0; l < nlines; l++) begin
            len  = (l == bad_idx) ? bad_len : H;
            href = 1'b1;
            for (int b = 0; b < len; b++) begin
                if ((b == 0) && (l == cmd_line)) begin
                    if (cmd_kind == 3)      reset    = 1'b1;
                    else if (cmd_kind == 2) cmd_stop = 1'b1;
                    else begin
                        cmd_start  = 1'b1;
                        cmd_single = (cmd_kind == 0);
                    end
                end
                step(); low++;
                if ((b == 0) && (l == cmd_line)) begin
                    reset = 1'b0; cmd_start = 1'b0; cmd_single = 1'b0;
                    cmd_stop = 1'b0;
                    if (cmd_kind == 3) begin
                        check_reset_values({name, "_midreset"});
                        m_mode = 0; m_ready = 0; m_stop = 0;
                        m_fc = 0; m_err = '0;
                        captured = 0; was_reset = 1;
                    end else if (cmd_kind == 2) begin
                        if (captured) m_stop = 1;
                        else          m_mode = 0;
                    end else if (m_mode == 0) begin
                        m_mode  = (cmd_kind == 0) ? 1 : 2;
                        m_err   = '0;
                        m_stop  = 0;
                        m_ready = 0;
                    end
                end
            end
            // Last line may end on the same edge as the vsync rise (gap 0).
            gap  = (l == nlines - 1) ? $urandom_range(0, 2) : $urandom_range(1, 4);
            href = 1'b0;
            if (captured && (len != H)) m_err[ERR_LINE] = 1'b1;
            for (int g = 0; g < gap; g++) begin
                step(); low++;
                if ((g == 0) && captured && (len != H)) begin
                    check({name, "_line_err_now"}, err, m_err);
                end
            end
        end
        cam_vsync = 1'b1; href = 1'b0;
        blank = $urandom_range(3, 6);
        repeat (blank) step();

        if (captured) begin
            m_fc++;
            if (nlines != V) m_err[ERR_FRAME] = 1'b1;
            exp_cap  = low;
            exp_done = 1;
            if ((m_mode == 1) || m_stop) begin
                m_mode = 0;
                m_stop = 0;
            end
        end else begin
            exp_cap  = 0;
            exp_done = 0;
        end
        m_ready = (m_mode != 0);

        if (!was_reset) check({name, "_cap_cycles"}, cap_cnt, exp_cap);
        check({name, "_done_pulses"}, done_cnt,    exp_done);
        check({name, "_frame_count"}, frame_count, m_fc % 256);
        check({name, "_err"},         err,         m_err);
        check({name, "_busy"},        busy,        (m_mode != 0));
        check({name, "_dp_reset"},    dp_reset,    (m_mode == 0));
    endtask

    initial begin
        reset = 1'b1; cmd_start = 1'b0; cmd_single = 1'b0; cmd_stop = 1'b0;
        cam_vsync = 1'b1; href = 1'b0;
        repeat (3) step();
        check_reset_values("por");
        reset = 1'b0;
        step();

        // single shot: only the first of two frames is captured
        blank_cmd("ss_start", 1'b1, 1'b1, 1'b0);
        run_frame("ss_f1", V, -1, H, -1, 0);
        run_frame("ss_f2", V, -1, H, -1, 0);

        // continuous, stop in the middle of frame 3
        blank_cmd("cont_start", 1'b1, 1'b0, 1'b0);
        run_frame("cont_f1", V, -1, H, -1, 0);
        run_frame("cont_f2", V, -1, H, -1, 0);
        run_frame("cont_f3", V, -1, H, $urandom_range(0, V - 1), 2);

        // short line
        blank_cmd("bl_start", 1'b1, 1'b1, 1'b0);
        run_frame("bad_line", V, $urandom_range(0, V - 1), H - 1, -1, 0);

        // short frame
        blank_cmd("bf_start", 1'b1, 1'b1, 1'b0);
        run_frame("bad_frame", V - 1, -1, H, -1, 0);

        // randomized sessions
        for (int it = 0; it < 5; it++) begin
            int nf;
            bit sg;
            sg = 1'($urandom_range(0, 1));
            nf = $urandom_range(1, 3);
            blank_cmd("rnd_start", 1'b1, sg, 1'b0);
            for (int f = 0; f < nf; f++) begin
                int nl, bi, bl;
                nl = $urandom_range(V - 1, V + 1);
                bi = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nl - 1) : -1;
                bl = $urandom_range(1, H + 2);
                run_frame("rnd", nl, bi, bl, -1, 0);
            end
            if (m_mode != 0) blank_cmd("rnd_stop", 1'b0, 1'b0, 1'b1);
        end

        // arm during an active frame: that frame must not be captured
        run_frame("arm_mid", V, -1, H, 1, 1);
        run_frame("arm_next", V, -1, H, -1, 0);
        blank_cmd("arm_stop", 1'b0, 1'b0, 1'b1);

        // start and stop together in IDLE: stop wins
        blank_cmd("start_stop", 1'b1, 1'b0, 1'b1);

        // stop while waiting in SYNC
        blank_cmd("sync_start", 1'b1, 1'b0, 1'b0);
        blank_cmd("sync_stop", 1'b0, 1'b0, 1'b1);

        // reset in the middle of line 2
        blank_cmd("rst_start", 1'b1, 1'b0, 1'b0);
        run_frame("rst_frame", V, -1, H, 2, 3);

`ifdef CAM_CTRL_TIMEOUT_EN
        // vsync stuck low after start: watchdog fires
        cam_vsync = 1'b0; href = 1'b0;
        cmd_start = 1'b1; cmd_single = 1'b0;
        cap_cnt = 0; done_cnt = 0;
        step();
        cmd_start = 1'b0;
        repeat (150) step();
        check("to_busy_before", busy, 1);
        repeat (60) step();
        check("to_busy_after",  busy,        0);
        check("to_err",         err,         3'b100);
        check("to_frame_count", frame_count, m_fc % 256);
        check("to_no_done",     done_cnt,    0);
        cam_vsync = 1'b1;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
